// File: rtl/gf_2ton_koa_reduce_accumulator.sv
// GHASH tail: XOR-sums the Karatsuba product lanes, reduces modulo x^NB_DATA + R(x)
// in two registered folds, and accumulates reduced beats across a frame.
module gf_2ton_koa_reduce_accumulator #(
  parameter int                 N_INSTANCES = 3,
  parameter int                 NB_DATA     = 128,
  parameter logic [NB_DATA-1:0] POLY_R      = 128'h87,
  parameter int                 NB_COUNT    = 16
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset_n,
  input  logic [N_INSTANCES*(2*NB_DATA+1)-1:0]   i_data_bus,
  input  logic                                   i_valid,
  input  logic                                   i_sof,
  input  logic                                   i_eof,
  output logic [NB_DATA-1:0]                     o_data,
  output logic                                   o_valid,
  output logic [NB_DATA-1:0]                     o_acc,
  output logic                                   o_acc_valid,
  output logic [NB_COUNT-1:0]                    o_block_count
);

  localparam int LANE_W = 2*NB_DATA + 1;
  localparam int PROD_W = 2*NB_DATA - 1;

  function automatic int poly_deg(input logic [NB_DATA-1:0] p);
    int d;
    d = 0;
    for (int i = 0; i < NB_DATA; i++) if (p[i]) d = i;
    return d;
  endfunction

  localparam int DEG_R = poly_deg(POLY_R);
  // Overflow of the first fold spans DEG_R-1 bits; keep at least one bit so slices stay legal.
  localparam int HI_W  = (DEG_R > 1) ? DEG_R - 1 : 1;
  localparam int S1_W  = NB_DATA + HI_W;

  function automatic logic [S1_W-1:0] clmul_hi(input logic [NB_DATA-2:0] a);
    logic [S1_W-1:0] res;
    logic [S1_W-1:0] r_ext;
    res   = '0;
    r_ext = S1_W'(POLY_R);
    for (int i = 0; i < NB_DATA-1; i++) if (a[i]) res ^= r_ext << i;
    return res;
  endfunction

  function automatic logic [NB_DATA-1:0] clmul_lo(input logic [HI_W-1:0] b);
    logic [NB_DATA-1:0] res;
    res = '0;
    for (int i = 0; i < HI_W; i++) if (b[i]) res ^= POLY_R << i;
    return res;
  endfunction

  logic [PROD_W-1:0]  s0_d, s0_q;
  logic [S1_W-1:0]    s1_d, s1_q;
  logic [NB_DATA-1:0] r;
  logic               v1, sof1, eof1;
  logic               v2, sof2, eof2;

  always_comb begin
    s0_d = '0;
    for (int k = 0; k < N_INSTANCES; k++) s0_d ^= i_data_bus[k*LANE_W +: PROD_W];
  end

  assign s1_d = S1_W'(s0_q[NB_DATA-1:0]) ^ clmul_hi(s0_q[PROD_W-1:NB_DATA]);
  assign r    = s1_q[NB_DATA-1:0] ^ clmul_lo(s1_q[S1_W-1:NB_DATA]);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v1   <= 1'b0;
      sof1 <= 1'b0;
      eof1 <= 1'b0;
      v2   <= 1'b0;
      sof2 <= 1'b0;
      eof2 <= 1'b0;
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      v1   <= i_valid;
      sof1 <= i_sof;
      eof1 <= i_eof;
      v2   <= v1;
      sof2 <= sof1;
      eof2 <= eof1;
      if (i_valid) s0_q <= s0_d;
      if (v1)      s1_q <= s1_d;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_acc         <= '0;
      o_acc_valid   <= 1'b0;
      o_block_count <= '0;
    end else begin
      o_valid     <= v2;
      o_acc_valid <= v2 & eof2;
      if (v2) begin
        o_data <= r;
        o_acc  <= (sof2 ? '0 : o_acc) ^ r;
        // Counter saturates rather than wrapping on very long frames.
        if (sof2)                o_block_count <= NB_COUNT'(1);
        else if (~&o_block_count) o_block_count <= o_block_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gf_2ton_koa_reduce_accumulator.sv
// Self-checking bench: directed vector table, hand-written frame sequences and a
// randomized run, all checked against a long-division reference with a frame model.
module tb_gf_2ton_koa_reduce_accumulator;

  localparam int NI    = 3;
  localparam int NB    = 128;
  localparam int NC    = 16;
  localparam int LW    = 2*NB + 1;
  localparam int BUS_W = NI*LW;
  localparam logic [NB-1:0] POLY = 128'h87;

  logic             clk;
  logic             rst_n;
  logic [BUS_W-1:0] bus;
  logic             valid, sof, eof;
  logic [NB-1:0]    o_data, o_acc;
  logic             o_valid, o_acc_valid;
  logic [NC-1:0]    o_block_count;

  gf_2ton_koa_reduce_accumulator #(
    .N_INSTANCES(NI), .NB_DATA(NB), .POLY_R(POLY), .NB_COUNT(NC)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_data_bus(bus), .i_valid(valid),
    .i_sof(sof), .i_eof(eof), .o_data(o_data), .o_valid(o_valid),
    .o_acc(o_acc), .o_acc_valid(o_acc_valid), .o_block_count(o_block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic             s;
    logic             e;
    logic [BUS_W-1:0] b;
  } beat_t;

  typedef struct {
    string         name;
    logic [LW-1:0] l0;
    logic [LW-1:0] l1;
    logic [LW-1:0] l2;
    logic [NB-1:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t         hist[$];
  logic [NB-1:0] m_data, m_acc;
  logic [NC-1:0] m_cnt;
  logic          m_valid, m_accv;

  function automatic logic [NB-1:0] ref_reduce(input logic [2*NB-1:0] p);
    logic [2*NB-1:0] q;
    q = p;
    for (int i = 2*NB-2; i >= NB; i--) begin
      if (q[i]) begin
        q[i] = 1'b0;
        q ^= (2*NB)'(POLY) << (i - NB);
      end
    end
    return q[NB-1:0];
  endfunction

  function automatic logic [NB-1:0] ref_beat(input logic [BUS_W-1:0] b);
    logic [2*NB-1:0] p;
    logic [LW-1:0]   lane;
    p = '0;
    for (int k = 0; k < NI; k++) begin
      lane = b[k*LW +: LW];
      p ^= {1'b0, 1'b0, lane[2*NB-2:0]};
    end
    return ref_reduce(p);
  endfunction

  function automatic logic [LW-1:0] rand_lane();
    logic [287:0] t;
    for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom;
    return t[LW-1:0];
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    return {rand_lane(), rand_lane(), rand_lane()};
  endfunction

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    beat_t inv;
    inv = '{v: 1'b0, s: 1'b0, e: 1'b0, b: '0};
    hist.delete();
    hist.push_back(inv);
    hist.push_back(inv);
    m_data = '0; m_acc = '0; m_cnt = '0; m_valid = 1'b0; m_accv = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, NB'(o_valid), NB'(m_valid));
    chk({tag, "_data"}, o_data, m_data);
    chk({tag, "_acc"}, o_acc, m_acc);
    chk({tag, "_accv"}, NB'(o_acc_valid), NB'(m_accv));
    chk({tag, "_cnt"}, NB'(o_block_count), NB'(m_cnt));
  endtask

  // One clock: record the beat seen at the edge, advance the model, check all outputs.
  task automatic step(input string tag);
    beat_t b;
    logic [NB-1:0] r;
    @(posedge clk);
    b = '{v: valid, s: sof, e: eof, b: bus};
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_back(b);
      b = hist.pop_front();
      m_valid = b.v;
      m_accv  = b.v & b.e;
      if (b.v) begin
        r      = ref_beat(b.b);
        m_data = r;
        m_acc  = (b.s ? '0 : m_acc) ^ r;
        m_cnt  = b.s ? NC'(1) : ((m_cnt == '1) ? m_cnt : m_cnt + 1'b1);
      end
    end
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [BUS_W-1:0] b);
    valid = v; sof = s; eof = e; bus = b;
  endtask

  task automatic idle();
    drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), rand_bus());
  endtask

  function automatic logic [LW-1:0] bitl(input int i);
    logic [LW-1:0] l;
    l = '0;
    l[i] = 1'b1;
    return l;
  endfunction

  vec_t vecs[6];
  logic [BUS_W-1:0] fb[4];
  logic [NB-1:0]    exp_sum;

  initial begin
    vec_t v;
    logic [LW-1:0] rl;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();

    // Reset held with random inputs, then release with no valid
    for (int i = 0; i < 5; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), rand_bus());
      step("reset_hold");
    end
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin idle(); step("post_reset"); end

    do rl = rand_lane(); while (rl[2*NB-2:0] == '0);
    vecs[0] = '{"fold1",    bitl(128), '0, '0, 128'h87};
    vecs[1] = '{"fold2",    '0, bitl(254), '0, 128'hC0000000_00000000_00000000_00001067};
    vecs[2] = '{"cancel",   rl, '0, rl, '0};
    vecs[3] = '{"no_red",   bitl(5), '0, '0, 128'h20};
    vecs[4] = '{"zero",     '0, '0, '0, '0};
    vecs[5] = '{"top_ign",  bitl(256), '0, bitl(0), 128'h1};

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      drive(1'b1, 1'b1, 1'b1, {v.l2, v.l1, v.l0});
      step(v.name);
      idle(); step(v.name);
      idle(); step(v.name);
      chk({v.name, "_vec_data"}, o_data, v.exp);
      chk({v.name, "_vec_acc"}, o_acc, v.exp);
      chk({v.name, "_vec_accv"}, NB'(o_acc_valid), NB'(1));
      chk({v.name, "_vec_cnt"}, NB'(o_block_count), NB'(1));
      idle(); step(v.name);
    end

    // Four-beat frame reducing to 1,2,4,8, with and without a mid-frame gap
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, i == 0, i == 3, {2*LW'(0), bitl(i)});
        step("frame4");
        if (g == 1 && i == 1) begin idle(); step("frame4_gap"); idle(); step("frame4_gap"); end
      end
      idle(); step("frame4");
      idle(); step("frame4");
      chk("frame4_acc", o_acc, 128'hF);
      chk("frame4_accv", NB'(o_acc_valid), NB'(1));
      chk("frame4_cnt", NB'(o_block_count), NB'(4));
      idle(); step("frame4");
      chk("frame4_pulse_end", NB'(o_acc_valid), NB'(0));
    end

    // Abandoned frame: two beats open, then a new sof..eof frame
    for (int i = 0; i < 4; i++) fb[i] = rand_bus();
    drive(1'b1, 1'b1, 1'b0, fb[0]); step("abandon");
    drive(1'b1, 1'b0, 1'b0, fb[1]); step("abandon");
    drive(1'b1, 1'b1, 1'b0, fb[2]); step("abandon");
    drive(1'b1, 1'b0, 1'b1, fb[3]); step("abandon");
    idle(); step("abandon");
    idle(); step("abandon");
    exp_sum = ref_beat(fb[2]) ^ ref_beat(fb[3]);
    chk("abandon_acc", o_acc, exp_sum);
    chk("abandon_cnt", NB'(o_block_count), NB'(2));
    chk("abandon_accv", NB'(o_acc_valid), NB'(1));
    idle(); step("abandon");

    // Async reset mid-frame
    drive(1'b1, 1'b1, 1'b0, rand_bus()); step("mid_rst");
    drive(1'b1, 1'b0, 1'b0, rand_bus()); step("mid_rst");
    drive(1'b1, 1'b0, 1'b1, rand_bus()); step("mid_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", o_acc, '0);
    chk("mid_rst_valid", NB'(o_valid), NB'(0));
    chk("mid_rst_cnt", NB'(o_block_count), NB'(0));
    step("mid_rst_low");
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin idle(); step("mid_rst_after"); end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, rand_bus());
      step("rand");
    end
    for (int i = 0; i < 4; i++) begin idle(); step("drain"); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
